// File: rtl/gcd_core.sv
// Subtraction-based GCD engine. Loads two unsigned operands, repeatedly
// subtracts the smaller from the larger until they converge, then reports the
// result with a one-cycle done pulse. The ordering decision comes from an
// external x<y comparator that is driven from x_reg/y_reg.
module gcd_core #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             x_lt_y,
  output logic [WIDTH-1:0] x_reg,
  output logic [WIDTH-1:0] y_reg,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iters
);

  // StSettle sits between convergence and StDone so that done lands k+2
  // edges after the edge that accepted go; gcd_out is already stable there.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSettle,
    StDone
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_iters;
  logic             r_ready;
  logic             r_done;

  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_eq;
  logic [WIDTH-1:0] w_x_minus_y;
  logic [WIDTH-1:0] w_y_minus_x;
  logic [CNT_W-1:0] w_iters_inc;

  // Local termination tests and subtraction results; ordering comes from x_lt_y.
  always_comb begin
    w_x_zero    = (r_x == '0);
    w_y_zero    = (r_y == '0);
    w_eq        = (r_x == r_y);
    w_x_minus_y = r_x - r_y;
    w_y_minus_x = r_y - r_x;
    w_iters_inc = r_iters + CNT_W'(1);
  end

  // Control FSM with registered datapath and registered ready/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_gcd   <= '0;
      r_iters <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (go) begin
            r_x     <= x_in;
            r_y     <= y_in;
            r_iters <= '0;
            r_ready <= 1'b0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          if (w_x_zero) begin
            r_gcd   <= r_y;
            r_state <= StSettle;
          end else if (w_y_zero) begin
            r_gcd   <= r_x;
            r_state <= StSettle;
          end else if (w_eq) begin
            r_gcd   <= r_x;
            r_state <= StSettle;
          end else if (x_lt_y) begin
            r_y     <= w_y_minus_x;
            r_iters <= w_iters_inc;
          end else begin
            r_x     <= w_x_minus_y;
            r_iters <= w_iters_inc;
          end
        end
        StSettle: begin
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Every output is a register; nothing from go/x_in/y_in reaches a port directly.
  always_comb begin
    x_reg   = r_x;
    y_reg   = r_y;
    ready   = r_ready;
    done    = r_done;
    gcd_out = r_gcd;
    iters   = r_iters;
  end

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core with a behavioural x<y comparator attached.
module tb_gcd_core;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 5;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [CNT_W-1:0] k;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             go;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             x_lt_y;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic [CNT_W-1:0] iters;

  int   n_tests;
  int   n_fail;
  int   n_done;
  exp_t exp_q[$];

  gcd_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .x_in   (x_in),
    .y_in   (y_in),
    .x_lt_y (x_lt_y),
    .x_reg  (x_reg),
    .y_reg  (y_reg),
    .ready  (ready),
    .done   (done),
    .gcd_out(gcd_out),
    .iters  (iters)
  );

  // Stand-in for the team's x<y comparator.
  assign x_lt_y = (x_reg < y_reg);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) if (done === 1'b1) n_done++;

  // Reference: subtraction GCD with step count.
  task automatic ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] g, output int k);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    p = a;
    q = b;
    k = 0;
    forever begin
      if (p == 0) begin g = q; break; end
      if (q == 0) begin g = p; break; end
      if (p == q) begin g = p; break; end
      if (p < q) q = q - p;
      else       p = p - q;
      k++;
    end
  endtask

  // Waits (bounded) for done, counting rising edges; returns at edge+1.
  task automatic wait_done(output int edges, output bit got);
    edges = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One full computation from IDLE: push model result, drive go, pop on done.
  task automatic test_one_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    int               k;
    int               edges;
    bit               got;
    exp_t             e;
    ref_gcd(a, b, g, k);
    exp_q.push_back('{g: g, k: CNT_W'(k)});
    x_in = a;
    y_in = b;
    go   = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(edges, got);
    e = exp_q.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout x=%0d y=%0d: no done within 40 edges", a, b);
      return;
    end
    n_tests++;
    if (edges !== k + 2) begin
      n_fail++;
      $display("FAIL latency x=%0d y=%0d: got %0d edges, want %0d", a, b, edges, k + 2);
    end
    n_tests++;
    if (gcd_out !== e.g) begin
      n_fail++;
      $display("FAIL gcd x=%0d y=%0d: got %0d, want %0d", a, b, gcd_out, e.g);
    end
    n_tests++;
    if (iters !== e.k) begin
      n_fail++;
      $display("FAIL iters x=%0d y=%0d: got %0d, want %0d", a, b, iters, e.k);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_done x=%0d y=%0d: ready=%b done=%b, want 1/0",
               a, b, ready, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    go    = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || gcd_out !== 0 || iters !== 0 ||
        x_reg !== 0 || y_reg !== 0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b done=%b gcd=%0d it=%0d x=%0d y=%0d, want 1 0 0 0 0 0",
               ready, done, gcd_out, iters, x_reg, y_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // 12,8 with operand trace.
  task automatic test_basic;
    int   edges;
    bit   got;
    exp_t e;
    exp_q.push_back('{g: 4'd4, k: 5'd2});
    x_in = 4'd12;
    y_in = 4'd8;
    go   = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    n_tests++;
    if (x_reg !== 4'd12 || y_reg !== 4'd8 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load: x=%0d y=%0d rdy=%b, want 12 8 0", x_reg, y_reg, ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (x_reg !== 4'd4 || y_reg !== 4'd8) begin
      n_fail++;
      $display("FAIL basic_step1: x=%0d y=%0d, want 4 8", x_reg, y_reg);
    end
    wait_done(edges, got);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || edges !== 3) begin
      n_fail++;
      $display("FAIL basic_latency: got=%b edges_after_go=%0d, want 1 4", got, edges + 1);
    end
    n_tests++;
    if (gcd_out !== e.g || iters !== e.k || y_reg !== 4'd4) begin
      n_fail++;
      $display("FAIL basic_result: gcd=%0d it=%0d y=%0d, want %0d %0d 4",
               gcd_out, iters, y_reg, e.g, e.k);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready: ready=%b done=%b, want 1 0", ready, done);
    end
  endtask

  task automatic test_zero_operands;
    test_one_gcd(4'd0, 4'd9);
    test_one_gcd(4'd7, 4'd0);
    test_one_gcd(4'd0, 4'd0);
  endtask

  task automatic test_go_ignored;
    int   edges;
    bit   got;
    int   d0;
    exp_t e;
    d0 = n_done;
    exp_q.push_back('{g: 4'd3, k: 5'd2});
    x_in = 4'd9;
    y_in = 4'd6;
    go   = 1'b1;
    @(posedge clk);
    #1;
    x_in = 4'd1;
    y_in = 4'd1;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(edges, got);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || edges !== 3) begin
      n_fail++;
      $display("FAIL ignored_go_latency: got=%b edges=%0d, want 1 3", got, edges);
    end
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (gcd_out !== e.g || iters !== e.k) begin
      n_fail++;
      $display("FAIL ignored_go_result: gcd=%0d it=%0d, want %0d %0d",
               gcd_out, iters, e.g, e.k);
    end
    n_tests++;
    if (n_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL ignored_go_done_count: got %0d, want 1", n_done - d0);
    end
  endtask

  task automatic test_reset_mid_calc;
    int d0;
    d0   = n_done;
    x_in = 4'd13;
    y_in = 4'd5;
    go   = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (gcd_out !== 0 || iters !== 0 || ready !== 1'b1 || done !== 1'b0 || x_reg !== 0) begin
      n_fail++;
      $display("FAIL async_reset: gcd=%0d it=%0d rdy=%b done=%b x=%0d, want 0 0 1 0 0",
               gcd_out, iters, ready, done, x_reg);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (n_done !== d0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_done: dones=%0d ready=%b, want 0 1", n_done - d0, ready);
    end
    test_one_gcd(4'd10, 4'd4);
  endtask

  task automatic test_worst_case;
    test_one_gcd(4'd15, 4'd1);
  endtask

  // go held high: second computation starts on the IDLE cycle after DONE.
  task automatic test_back_to_back;
    int   edges;
    bit   got;
    exp_t e;
    exp_q.push_back('{g: 4'd4, k: 5'd2});
    exp_q.push_back('{g: 4'd4, k: 5'd2});
    x_in = 4'd12;
    y_in = 4'd8;
    go   = 1'b1;
    @(posedge clk);
    #1;
    wait_done(edges, got);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || edges !== 4 || gcd_out !== e.g) begin
      n_fail++;
      $display("FAIL b2b_first: got=%b edges=%0d gcd=%0d, want 1 4 %0d", got, edges, gcd_out, e.g);
    end
    wait_done(edges, got);
    go = 1'b0;
    e  = exp_q.pop_front();
    n_tests++;
    if (!got || edges !== 6 || gcd_out !== e.g || iters !== e.k) begin
      n_fail++;
      $display("FAIL b2b_second: got=%b gap=%0d gcd=%0d it=%0d, want 1 6 %0d %0d",
               got, edges, gcd_out, iters, e.g, e.k);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    int d0;
    d0 = n_done;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        test_one_gcd(WIDTH'(a), WIDTH'(b));
      end
    end
    n_tests++;
    if (n_done - d0 !== 256) begin
      n_fail++;
      $display("FAIL sweep_done_count: got %0d, want 256", n_done - d0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_done  = 0;
    test_reset();
    test_basic();
    test_worst_case();
    test_zero_operands();
    test_go_ignored();
    test_reset_mid_calc();
    test_back_to_back();
    test_sweep();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
